grid_cell_scanner: RTL and testbench
====================================

GRID_CELL_SCANNER -- requirements
Module: grid_cell_scanner

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: a cell draw request is present.
REQ-004 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-005 SHALL have port char_x, input, 6 bits: grid column of the requested cell (0..49 legal).
REQ-006 SHALL have port char_y, input, 6 bits: grid row of the requested cell (0..39 legal).
REQ-007 SHALL have port rom_row, output, 4 bits: glyph row address (0..9) sent to the font ROM.
REQ-008 SHALL have port rom_bits, input, 10 bits: glyph row data, valid the cycle after rom_row is presented; bit 9 is the leftmost pixel.
REQ-009 SHALL have port pix_valid, output, 1 bit: pixel_x, pixel_y and pix_on are valid.
REQ-010 SHALL have port pix_ready, input, 1 bit: the downstream consumer accepts the pixel.
REQ-011 SHALL have port pixel_x, output, 10 bits: screen x of the emitted pixel.
REQ-012 SHALL have port pixel_y, output, 10 bits: screen y of the emitted pixel.
REQ-013 SHALL have port pix_on, output, 1 bit: glyph bit for the emitted pixel.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a cell completes.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse when a request is out of range.

Function
REQ-016 SHALL use these fixed grid constants: X_ORIGIN=140, Y_ORIGIN=80, CELL=10, COLS=50, ROWS=40 (inverse of the pixel-to-grid mapping).
REQ-017 SHALL implement the states IDLE, FETCH, LOAD, EMIT and DONE.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high, which latches char_x and char_y.
REQ-019 SHALL, on accepting a request with char_x>=50 or char_y>=40, pulse err for 1 cycle the next cycle, stay in IDLE and emit no pixels.
REQ-020 SHALL, on accepting a legal request, move IDLE->FETCH with the row counter at 0 and the column counter at 0.
REQ-021 SHALL, in FETCH, drive rom_row = row counter for 1 cycle, then move to LOAD.
REQ-022 SHALL, in LOAD, capture rom_bits into a 10-bit row register, then move to EMIT.
REQ-023 SHALL, in EMIT, assert pix_valid with pixel_x = 140 + 10*cx + col, pixel_y = 80 + 10*cy + row and pix_on = rowreg[9-col], with all arithmetic in 10 bits and no overflow for legal cells.
REQ-024 SHALL hold pixel_x, pixel_y, pix_on and pix_valid stable while pix_valid=1 and pix_ready=0.
REQ-025 SHALL, on a pixel handshake with col<9, increment col and remain in EMIT.
REQ-026 SHALL, on a pixel handshake with col=9 and row<9, set col to 0, increment row and move to FETCH.
REQ-027 SHALL, on a pixel handshake with col=9 and row=9, move to DONE.
REQ-028 SHALL, in DONE, pulse done for 1 cycle, then return to IDLE with req_ready=1 the following cycle.
REQ-029 SHALL take 12 cycles per row with no backpressure, and 120 cycles from acceptance to the last pixel handshake.
REQ-030 SHALL ignore req_valid in every state other than IDLE; the latched coordinates are not altered mid-cell.
REQ-031 SHALL keep pix_valid low in every state other than EMIT.

Reset
REQ-032 SHALL, while rst=1, force the state to IDLE and drive req_ready=0, pix_valid=0, done=0, err=0, pixel_x=0, pixel_y=0, pix_on=0 and rom_row=0.
REQ-033 SHALL clear the row register, counters and latched coordinates on reset.
REQ-034 SHALL assert req_ready in the first cycle after rst deasserts.
REQ-035 SHALL, on reset asserted mid-cell, abandon the cell at the next edge with no done pulse and no further pixels.

Verification
REQ-036 SHALL cover: request (0,0), rom_bits=10'h3FF every row, pix_ready=1 -> 100 pixels, x 140..149, y 80..89 in row-major order, all pix_on=1, done 121 cycles after acceptance.
REQ-037 SHALL cover: request (49,39), pix_ready=1 -> first pixel (630,470), last pixel (639,479), done pulses once.
REQ-038 SHALL cover: request (50,0), then (0,40) -> err pulses once each, pix_valid never asserts, req_ready stays 1.
REQ-039 SHALL cover: rom_bits=10'h200 on row 0, pix_ready held low 5 cycles on the first pixel -> (140,80,pix_on=1) held stable for 5 cycles, then (141,80,pix_on=0).
REQ-040 SHALL cover: rst asserted after 37 pixels -> pix_valid=0 and done=0 next cycle; req_ready=1 the cycle after rst drops; a new (1,1) request starts at (150,90).
REQ-041 SHALL cover: req_valid toggled during EMIT with different coordinates -> ignored; the cell in progress completes unchanged.

Source files
------------

// File: rtl/grid_cell_scanner.sv
// ---------------------------------------------------------------------------
// grid_cell_scanner
//
// Purpose:
//   Expands one character cell of a 50 x 40 text grid into its 10 x 10 screen
//   pixels. A request names a grid cell (char_x, char_y). For each of the ten
//   glyph rows the block fetches one row of font bits from an external
//   synchronous ROM. It then streams ten pixels through a valid/ready
//   handshake, leftmost pixel first. The grid's top-left corner sits at
//   screen (140, 80).
//
// Ports:
//   clk        system clock, every register updates on its rising edge
//   rst        synchronous active-high reset
//   req_valid  cell draw request present
//   req_ready  block idle and able to accept a request
//   char_x     grid column 0..49 (larger values are rejected)
//   char_y     grid row 0..39 (larger values are rejected)
//   rom_row    glyph row address presented to the font ROM
//   rom_bits   glyph row data, valid one cycle after rom_row; bit 9 = leftmost
//   pix_valid  pixel_x / pixel_y / pix_on are valid
//   pix_ready  downstream accepts the current pixel
//   pixel_x    screen x of the current pixel
//   pixel_y    screen y of the current pixel
//   pix_on     glyph bit of the current pixel
//   done       one-cycle pulse once the last pixel of a cell has been taken
//   err        one-cycle pulse after an out-of-range request was accepted
// ---------------------------------------------------------------------------
module grid_cell_scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] char_x,
    input  logic [5:0] char_y,
    output logic [3:0] rom_row,
    input  logic [9:0] rom_bits,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pix_on,
    output logic       done,
    output logic       err
);

    // Grid geometry (inverse of the pixel-to-grid mapping used elsewhere).
    localparam logic [9:0] X_ORIGIN = 10'd140;
    localparam logic [9:0] Y_ORIGIN = 10'd80;
    localparam logic [9:0] CELL     = 10'd10;
    localparam logic [5:0] COLS     = 6'd50;
    localparam logic [5:0] ROWS     = 6'd40;
    localparam logic [3:0] LAST_IDX = 4'd9;   // last row / column inside a cell

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] row_reg,   row_next;
    logic [3:0] col_reg,   col_next;
    logic [5:0] cx_reg,    cx_next;
    logic [5:0] cy_reg,    cy_next;
    logic [9:0] bits_reg,  bits_next;
    logic       err_reg,   err_next;

    logic       in_range;
    logic [9:0] bits_rev;
    logic [9:0] cx_ext;
    logic [9:0] cy_ext;
    logic [9:0] base_x;
    logic [9:0] base_y;

    // The ROM delivers the leftmost pixel in bit 9. Reversing the row once
    // lets the column counter index the glyph row directly.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_bit_rev
            assign bits_rev[gi] = bits_reg[9 - gi];
        end
    endgenerate

    // Top-left pixel of the latched cell. The largest legal value is
    // 140 + 490 + 9 = 639 for x and 80 + 390 + 9 = 479 for y, so 10 bits
    // hold every legal result without wrapping.
    assign cx_ext = {4'd0, cx_reg};
    assign cy_ext = {4'd0, cy_reg};
    assign base_x = X_ORIGIN + cx_ext * CELL;
    assign base_y = Y_ORIGIN + cy_ext * CELL;

    assign in_range = (char_x < COLS) && (char_y < ROWS);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            row_reg   <= 4'd0;
            col_reg   <= 4'd0;
            cx_reg    <= 6'd0;
            cy_reg    <= 6'd0;
            bits_reg  <= 10'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            cx_reg    <= cx_next;
            cy_reg    <= cy_next;
            bits_reg  <= bits_next;
            err_reg   <= err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        cx_next    = cx_reg;
        cy_next    = cy_reg;
        bits_next  = bits_reg;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone
                // completes the handshake. The coordinates change only
                // here; req_valid is ignored in every other state.
                if (req_valid) begin
                    cx_next = char_x;
                    cy_next = char_y;
                    if (in_range) begin
                        row_next   = 4'd0;
                        col_next   = 4'd0;
                        state_next = FETCH;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            FETCH: begin
                // rom_row is driven this cycle. The ROM answers next cycle.
                state_next = LOAD;
            end

            LOAD: begin
                bits_next  = rom_bits;
                state_next = EMIT;
            end

            EMIT: begin
                if (pix_ready) begin
                    if (col_reg != LAST_IDX) begin
                        col_next = col_reg + 4'd1;
                    end else if (row_reg != LAST_IDX) begin
                        col_next   = 4'd0;
                        row_next   = row_reg + 4'd1;
                        state_next = FETCH;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Every output is forced low while rst is high. A reset that arrives
    // mid-cell therefore silences the pixel stream in that same cycle,
    // before the registers clear on the next edge.
    always_comb begin
        req_ready = 1'b0;
        rom_row   = 4'd0;
        pix_valid = 1'b0;
        pixel_x   = 10'd0;
        pixel_y   = 10'd0;
        pix_on    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        if (!rst) begin
            err = err_reg;
            case (state_reg)
                IDLE: begin
                    req_ready = 1'b1;
                end
                FETCH: begin
                    rom_row = row_reg;
                end
                EMIT: begin
                    // Every term below is a register, so the pixel stays
                    // stable while the consumer stalls.
                    pix_valid = 1'b1;
                    pixel_x   = base_x + {6'd0, col_reg};
                    pixel_y   = base_y + {6'd0, row_reg};
                    pix_on    = bits_rev[col_reg];
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_cell_scanner.sv
// ---------------------------------------------------------------------------
// tb_grid_cell_scanner
//
// Directed bench for grid_cell_scanner. A queue model expands each legal
// request into its 100 expected pixels, computed from the screen mapping
// and the glyph table. A negedge monitor compares every valid pixel with the
// head of that queue, and it checks the reset-state outputs. Stimulus tasks
// add literal checks on corner pixels, latencies and pulse counts.
// Inputs change 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grid_cell_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [5:0] char_x = 6'd0;
    logic [5:0] char_y = 6'd0;
    logic [3:0] rom_row;
    logic [9:0] rom_bits = 10'd0;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pix_on;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    grid_cell_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .char_x    (char_x),
        .char_y    (char_y),
        .rom_row   (rom_row),
        .rom_bits  (rom_bits),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .pix_on    (pix_on),
        .done      (done),
        .err       (err)
    );

    // Synchronous font ROM: data follows the address by one clock.
    logic [9:0] font [10];
    always @(posedge clk) rom_bits <= font[rom_row];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int x;
        int y;
        int on;
    } pix_t;

    pix_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    int pix_count    = 0;
    int first_x      = 0;
    int first_y      = 0;
    int first_on     = 0;
    int last_x       = 0;
    int last_y       = 0;
    int last_on      = 0;
    int last_hs_edge = 0;
    int done_cnt     = 0;
    int done_edge    = 0;
    int err_cnt      = 0;
    int err_edge     = 0;
    int accept_edge  = 0;
    bit hold_prev    = 1'b0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Model: the 100 pixels of a cell in row-major order.
    function automatic void push_cell(input int cx, input int cy);
        pix_t p;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                p.x  = 140 + 10 * cx + c;
                p.y  = 80 + 10 * cy + r;
                p.on = int'(font[r][9 - c]);
                exp_q.push_back(p);
            end
        end
    endfunction

    // Monitor: compares every valid pixel with the head of the model queue.
    always @(negedge clk) begin
        pix_t e;
        if (rst) begin
            check("rst_outputs_zero",
                  int'({req_ready, pix_valid, done, err, pix_on, pixel_x, pixel_y, rom_row}), 0);
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) check("hold_valid", int'(pix_valid), 1);
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("pixel_x", int'(pixel_x), e.x);
                    check("pixel_y", int'(pixel_y), e.y);
                    check("pix_on",  int'(pix_on),  e.on);
                    if (pix_ready) begin
                        e = exp_q.pop_front();
                        if (pix_count == 0) begin
                            first_x  = int'(pixel_x);
                            first_y  = int'(pixel_y);
                            first_on = int'(pix_on);
                        end
                        last_x       = int'(pixel_x);
                        last_y       = int'(pixel_y);
                        last_on      = int'(pix_on);
                        last_hs_edge = edge_cnt;
                        pix_count++;
                    end
                end
            end
            hold_prev = pix_valid && !pix_ready;
            if (done) begin
                done_cnt++;
                done_edge = edge_cnt;
            end
            if (err) begin
                err_cnt++;
                err_edge = edge_cnt;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int cx, input int cy);
        int t = 0;
        while (!req_ready && t < 300) begin
            step();
            t++;
        end
        check("req_ready_wait", int'(req_ready), 1);
        if (cx < 50 && cy < 40) push_cell(cx, cy);
        pix_count   = 0;
        accept_edge = edge_cnt;
        char_x      = 6'(cx);
        char_y      = 6'(cy);
        req_valid   = 1'b1;
        step();
        req_valid   = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int t  = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < max_cycles) begin
            step();
            t++;
        end
        check("done_seen", int'(done_cnt != d0), 1);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!pix_valid && t < 30) begin
            step();
            t++;
        end
        check(name, int'(pix_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;

        for (int r = 0; r < 10; r++) font[r] = 10'h3FF;

        // Reset, then req_ready must rise straight away.
        repeat (3) step();
        rst = 1'b0;
        step();
        check("req_ready_after_rst", int'(req_ready), 1);
        check("no_pix_after_rst", int'(pix_valid), 0);

        // Cell (0,0), solid glyph, no backpressure.
        pix_ready = 1'b1;
        send_req(0, 0);
        wait_done(300);
        check("c00_done_latency", done_edge - accept_edge, 121);
        check("c00_last_hs_latency", last_hs_edge - accept_edge, 120);
        check("c00_pix_count", pix_count, 100);
        check("c00_first_x", first_x, 140);
        check("c00_first_y", first_y, 80);
        check("c00_last_x", last_x, 149);
        check("c00_last_y", last_y, 89);
        check("c00_last_on", last_on, 1);
        check("c00_ready_after_done", int'(req_ready), 1);
        check("c00_done_one_cycle", int'(done), 0);
        check("c00_done_count", done_cnt, 1);

        // Cell (49,39), striped glyph.
        for (int r = 0; r < 10; r++) font[r] = (r % 2 == 0) ? 10'h2AA : 10'h155;
        send_req(49, 39);
        wait_done(300);
        check("c4939_first_x", first_x, 630);
        check("c4939_first_y", first_y, 470);
        check("c4939_first_on", first_on, 1);
        check("c4939_last_x", last_x, 639);
        check("c4939_last_y", last_y, 479);
        check("c4939_last_on", last_on, 1);
        check("c4939_done_count", done_cnt, 2);

        // Out-of-range requests.
        e0 = err_cnt;
        send_req(50, 0);
        for (int i = 0; i < 3; i++) begin
            check("err1_req_ready", int'(req_ready), 1);
            step();
        end
        check("err1_count", err_cnt, e0 + 1);
        check("err1_latency", err_edge - accept_edge, 1);
        send_req(0, 40);
        for (int i = 0; i < 3; i++) begin
            check("err2_req_ready", int'(req_ready), 1);
            step();
        end
        check("err2_count", err_cnt, e0 + 2);
        check("err2_latency", err_edge - accept_edge, 1);
        check("err_no_pixels", pix_count, 0);
        check("err_no_done", done_cnt, 2);

        // Backpressure on the first pixel.
        for (int r = 0; r < 10; r++) font[r] = 10'h000;
        font[0]   = 10'h200;
        pix_ready = 1'b0;
        send_req(0, 0);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check("bp_hold_x", int'(pixel_x), 140);
            check("bp_hold_y", int'(pixel_y), 80);
            check("bp_hold_on", int'(pix_on), 1);
        end
        step();
        pix_ready = 1'b1;
        check("bp_take_x", int'(pixel_x), 140);
        step();
        check("bp_next_x", int'(pixel_x), 141);
        check("bp_next_y", int'(pixel_y), 80);
        check("bp_next_on", int'(pix_on), 0);
        wait_done(300);
        check("bp_pix_count", pix_count, 100);

        // Reset after 37 pixels of cell (2,3).
        for (int r = 0; r < 10; r++) font[r] = 10'(r * 37 + 5);
        d0 = done_cnt;
        send_req(2, 3);
        begin
            int t = 0;
            while (pix_count < 37 && t < 200) begin
                step();
                t++;
            end
        end
        check("rst_mid_pix_count", pix_count, 37);
        rst = 1'b1;
        exp_q.delete();
        step();
        check("rst_mid_pix_valid", int'(pix_valid), 0);
        check("rst_mid_done", int'(done), 0);
        rst = 1'b0;
        step();
        check("rst_mid_req_ready", int'(req_ready), 1);
        check("rst_mid_no_done", done_cnt, d0);
        check("rst_mid_no_more_pix", pix_count, 37);
        send_req(1, 1);
        wait_valid("c11_valid");
        check("c11_first_x", int'(pixel_x), 150);
        check("c11_first_y", int'(pixel_y), 90);
        wait_done(300);
        check("c11_last_x", last_x, 159);
        check("c11_last_y", last_y, 99);

        // req_valid with other coordinates during EMIT must be ignored.
        for (int r = 0; r < 10; r++) font[r] = 10'h3C3 ^ 10'(r);
        d0 = done_cnt;
        send_req(3, 4);
        wait_valid("ign_valid");
        for (int i = 0; i < 30; i++) begin
            req_valid = i[0];
            char_x    = 6'd7;
            char_y    = 6'd8;
            step();
        end
        req_valid = 1'b0;
        wait_done(300);
        check("ign_pix_count", pix_count, 100);
        check("ign_last_x", last_x, 179);
        check("ign_last_y", last_y, 129);
        check("ign_done_latency", done_edge - accept_edge, 121);
        check("ign_done_count", done_cnt, d0 + 1);

        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
